// File: rtl/sum_rr_scheduler_if.sv
// Request/stream/result bundle for sum_rr_scheduler.
// The scheduler takes the slave modport and the requesters take the master modport.
interface sum_rr_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*WIDTH-1:0]   data_in;
    logic [NUM_REQ-1:0]         grant;
    logic                       busy;
    logic [WIDTH-1:0]           result;
    logic [$clog2(NUM_REQ)-1:0] result_id;
    logic                       result_valid;
    logic                       result_ovf;
    logic                       result_trunc;

    modport master (
        output req, data_in,
        input  grant, busy, result, result_id, result_valid, result_ovf, result_trunc
    );

    modport slave (
        input  req, data_in,
        output grant, busy, result, result_id, result_valid, result_ovf, result_trunc
    );
endinterface

// File: rtl/sum_rr_scheduler.sv
// Round-robin scheduler sharing one zero-terminated accumulator among NUM_REQ requesters.
// Define SUM_SATURATE_EN for saturating addition; the default build wraps modulo 2^WIDTH.
module sum_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16
) (
    input  logic             clock,
    input  logic             reset,
    sum_rr_scheduler_if.slave bus
);
    localparam int          IDW  = $clog2(NUM_REQ);
    localparam int          CW   = $clog2(MAX_LEN + 1);
    localparam int unsigned NR_U = NUM_REQ;

    typedef enum logic [1:0] {IDLE, SUM, DONE} state_e;

    state_e             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     win_q, win_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               trunc_q, trunc_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               busy_q, busy_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [IDW-1:0]     res_id_q, res_id_d;
    logic               valid_q, valid_d;
    logic               res_ovf_q, res_ovf_d;
    logic               res_trunc_q, res_trunc_d;

    logic               found;
    logic [IDW-1:0]     pick;
    logic [IDW-1:0]     next_id;
    logic [WIDTH-1:0]   word;
    logic [WIDTH:0]     sum_w;
    logic [WIDTH-1:0]   acc_add;
    logic               finish;

    // First active request at or above the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        int unsigned idx;
        logic [IDW-1:0] cand;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        cand  = '0;
        for (int unsigned i = 0; i < NR_U; i++) begin
            idx  = (32'(ptr_q) + i) % NR_U;
            cand = IDW'(idx);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign next_id = (win_q == IDW'(NUM_REQ - 1)) ? '0 : win_q + IDW'(1);
    assign word    = bus.data_in[32'(win_q) * WIDTH +: WIDTH];
    assign sum_w   = {1'b0, acc_q} + {1'b0, word};

`ifdef SUM_SATURATE_EN
    assign acc_add = sum_w[WIDTH] ? '1 : sum_w[WIDTH-1:0];
`else
    assign acc_add = sum_w[WIDTH-1:0];
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        trunc_d     = trunc_q;
        grant_d     = grant_q;
        busy_d      = busy_q;
        res_d       = res_q;
        res_id_d    = res_id_q;
        valid_d     = 1'b0;
        res_ovf_d   = res_ovf_q;
        res_trunc_d = res_trunc_q;
        finish      = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    win_d   = pick;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    trunc_d = 1'b0;
                    grant_d = NUM_REQ'(1) << pick;
                    busy_d  = 1'b1;
                    state_d = SUM;
                end
            end
            SUM: begin
                if (!bus.req[win_q]) begin
                    grant_d = '0;
                    busy_d  = 1'b0;
                    ptr_d   = next_id;
                    state_d = IDLE;
                end else if (word != '0) begin
                    acc_d = acc_add;
                    ovf_d = ovf_q | sum_w[WIDTH];
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(MAX_LEN - 1)) begin
                        trunc_d = 1'b1;
                        finish  = 1'b1;
                    end
                end else begin
                    finish = 1'b1;
                end
                // Result registers load on the way into DONE so the pulse is registered.
                if (finish) begin
                    grant_d     = '0;
                    state_d     = DONE;
                    res_d       = acc_d;
                    res_id_d    = win_q;
                    valid_d     = 1'b1;
                    res_ovf_d   = ovf_d;
                    res_trunc_d = trunc_d;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                ptr_d   = next_id;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            win_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            trunc_q     <= 1'b0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            res_q       <= '0;
            res_id_q    <= '0;
            valid_q     <= 1'b0;
            res_ovf_q   <= 1'b0;
            res_trunc_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            trunc_q     <= trunc_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            res_q       <= res_d;
            res_id_q    <= res_id_d;
            valid_q     <= valid_d;
            res_ovf_q   <= res_ovf_d;
            res_trunc_q <= res_trunc_d;
        end
    end

    assign bus.grant        = grant_q;
    assign bus.busy         = busy_q;
    assign bus.result       = res_q;
    assign bus.result_id    = res_id_q;
    assign bus.result_valid = valid_q;
    assign bus.result_ovf   = res_ovf_q;
    assign bus.result_trunc = res_trunc_q;
endmodule

// File: tb/tb_sum_rr_scheduler.sv
// Self-checking bench for sum_rr_scheduler (NUM_REQ=4, WIDTH=8, MAX_LEN=8).
// Streams are modelled as word arrays; sums and service order come from a reference model.
module tb_sum_rr_scheduler;
    localparam int NR = 4;
    localparam int W  = 8;
    localparam int ML = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    sum_rr_scheduler_if #(.NUM_REQ(NR), .WIDTH(W)) bus_if ();

    sum_rr_scheduler #(.NUM_REQ(NR), .WIDTH(W), .MAX_LEN(ML)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus_if)
    );

    typedef struct {
        int id;
        int res;
        int ovf;
        int trunc;
    } res_t;

    res_t       got[$];
    logic [7:0] strm [NR][32];
    int         gcnt [NR];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         ptr_m = 0;
    int         last_res = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One cycle: sample at the falling edge, present the next word of each granted stream,
    // record results and release the request of a requester whose result just appeared.
    task automatic cyc();
        res_t g;
        @(negedge clock);
        chk("grant_onehot", 32'($countones(bus_if.grant) <= 1), 32'(1));
        if (bus_if.result_valid) begin
            g.id    = int'(bus_if.result_id);
            g.res   = int'(bus_if.result);
            g.ovf   = int'(bus_if.result_ovf);
            g.trunc = int'(bus_if.result_trunc);
            got.push_back(g);
            bus_if.req[bus_if.result_id] = 1'b0;
        end
        for (int i = 0; i < NR; i++) begin
            if (bus_if.grant[i]) begin
                bus_if.data_in[i*W +: W] = strm[i][gcnt[i] % 32];
                gcnt[i]++;
            end
        end
    endtask

    task automatic load_const(input int r, input int v, input int n);
        for (int k = 0; k < 32; k++)
            strm[r][k] = (k < n) ? 8'(v) : ((k == n) ? 8'd0 : 8'd7);
        gcnt[r] = 0;
        bus_if.data_in[r*W +: W] = strm[r][0];
    endtask

    task automatic load_rand(input int r);
        int len;
        len = int'($urandom_range(0, 10));
        for (int k = 0; k < 32; k++)
            strm[r][k] = (k < len) ? 8'($urandom_range(1, 255)) : ((k == len) ? 8'd0 : 8'd7);
        gcnt[r] = 0;
        bus_if.data_in[r*W +: W] = strm[r][0];
    endtask

    // Expected outcome of stream r from the accumulation rules.
    function automatic void model(input int r, output int res, output int ovf,
                                  output int trunc, output int used);
        res = 0; ovf = 0; trunc = 0; used = 0;
        for (int k = 0; k < 32; k++) begin
            used = k + 1;
            if (strm[r][k] == 8'd0) break;
            res += int'(strm[r][k]);
            if (res > 255) begin
                ovf = 1;
`ifdef SUM_SATURATE_EN
                res = 255;
`else
                res -= 256;
`endif
            end
            if (used == ML) begin
                trunc = 1;
                break;
            end
        end
    endfunction

    function automatic int next_winner(input logic [NR-1:0] mask);
        for (int k = 0; k < NR; k++)
            if (mask[(ptr_m + k) % NR]) return (ptr_m + k) % NR;
        return 0;
    endfunction

    task automatic expect_result(input int r);
        int   res, ovf, trunc, used;
        res_t g;
        model(r, res, ovf, trunc, used);
        for (int k = 0; k < 300 && got.size() == 0; k++) cyc();
        n_cmp++;
        assert (got.size() != 0) else begin
            n_bad++;
            $error("FAIL result_timeout: observed no result expected result from req %0d", r);
        end
        if (got.size() != 0) begin
            g = got.pop_front();
            chk("result_id", 32'(g.id), 32'(r));
            chk("result", 32'(g.res), 32'(res));
            chk("result_ovf", 32'(g.ovf), 32'(ovf));
            chk("result_trunc", 32'(g.trunc), 32'(trunc));
            chk("words_consumed", 32'(gcnt[r]), 32'(used));
        end
        ptr_m    = (r + 1) % NR;
        last_res = res;
    endtask

    initial begin
        bus_if.req     = '0;
        bus_if.data_in = '0;
        for (int i = 0; i < NR; i++) load_const(i, 7, 0);

        // Reset values
        cyc();
        cyc();
        chk("rst_grant", 32'(bus_if.grant), 32'(0));
        chk("rst_busy", 32'(bus_if.busy), 32'(0));
        chk("rst_result", 32'(bus_if.result), 32'(0));
        chk("rst_result_id", 32'(bus_if.result_id), 32'(0));
        chk("rst_valid", 32'(bus_if.result_valid), 32'(0));
        chk("rst_ovf_trunc", 32'({bus_if.result_ovf, bus_if.result_trunc}), 32'(0));
        reset = 1'b0;
        cyc();

        // Stream 4,4,4,0 on requester 0, one-cycle grant latency
        load_const(0, 4, 3);
        bus_if.req[0] = 1'b1;
        cyc();
        chk("t1_grant_latency", 32'(bus_if.grant), 32'(4'b0001));
        chk("t1_busy", 32'(bus_if.busy), 32'(1));
        expect_result(0);
        chk("t1_sum12", 32'(last_res), 32'(12));
        cyc();
        chk("t1_idle_busy", 32'(bus_if.busy), 32'(0));

        // Round-robin order from a fresh reset
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        ptr_m = 0;
        load_rand(1);
        load_rand(3);
        bus_if.req[1] = 1'b1;
        bus_if.req[3] = 1'b1;
        expect_result(1);
        for (int k = 0; k < 50 && !bus_if.grant[3]; k++) cyc();
        chk("t2_grant3", 32'(bus_if.grant), 32'(4'b1000));
        load_rand(0);
        load_rand(1);
        bus_if.req[0] = 1'b1;
        bus_if.req[1] = 1'b1;
        expect_result(3);
        expect_result(0);
        expect_result(1);

        // Overflow: 200,100,0
        load_const(2, 200, 2);
        strm[2][1] = 8'd100;
        bus_if.req[2] = 1'b1;
        expect_result(2);

        // Truncation at MAX_LEN with a constant-1 stream
        load_const(0, 1, 20);
        bus_if.req[0] = 1'b1;
        expect_result(0);
        chk("t4_exactly_maxlen", 32'(gcnt[0]), 32'(ML));

        // Abort: requester 1 drops req mid-stream, pending requester 2 follows
        cyc();
        load_const(1, 5, 20);
        load_const(2, 6, 2);
        bus_if.req[1] = 1'b1;
        for (int k = 0; k < 50 && gcnt[1] == 0; k++) cyc();
        cyc();
        bus_if.req[1] = 1'b0;
        bus_if.req[2] = 1'b1;
        cyc();
        chk("t5_abort_grant", 32'(bus_if.grant), 32'(0));
        chk("t5_abort_busy", 32'(bus_if.busy), 32'(0));
        cyc();
        chk("t5_next_grant", 32'(bus_if.grant), 32'(4'b0100));
        chk("t5_no_result", 32'(got.size()), 32'(0));
        chk("t5_result_kept", 32'(bus_if.result), 32'(last_res));
        ptr_m = 2;
        expect_result(2);

        // Asynchronous reset in the middle of a stream
        load_const(3, 9, 20);
        bus_if.req[3] = 1'b1;
        for (int k = 0; k < 50 && gcnt[3] < 2; k++) cyc();
        reset = 1'b1;
        #1;
        chk("t6_async_grant", 32'(bus_if.grant), 32'(0));
        chk("t6_async_busy", 32'(bus_if.busy), 32'(0));
        chk("t6_async_valid", 32'(bus_if.result_valid), 32'(0));
        bus_if.req = '0;
        cyc();
        reset = 1'b0;
        ptr_m = 0;
        load_const(0, 3, 3);
        load_const(2, 4, 1);
        bus_if.req = 4'b0101;
        expect_result(0);
        chk("t6_sum9", 32'(last_res), 32'(9));
        expect_result(2);

        // Randomized batches of simultaneous requests
        for (int t = 0; t < 30; t++) begin
            logic [NR-1:0] m;
            m = NR'($urandom_range(1, 15));
            for (int i = 0; i < NR; i++) if (m[i]) load_rand(i);
            bus_if.req = m;
            for (int s = 0; s < NR && bus_if.req != '0; s++)
                expect_result(next_winner(bus_if.req));
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sum_rr_scheduler.md
Name: sum_rr_scheduler

Overview:
- Round-robin scheduler that shares one 8-bit zero-terminated accumulator datapath between NUM_REQ requesters.
- Each requester presents a stream of words terminated by 0; the block grants one requester at a time, accumulates its stream and returns the sum with the requester ID.
- Sits in front of the result Register: result_valid drives the register enable and result drives its D input.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 8, data and sum width
- MAX_LEN, 16, max nonzero words per stream before forced termination (>=1)

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- req  input  NUM_REQ  per-requester request; held high until its result_valid or an abort
- data_in  input  NUM_REQ*WIDTH  packed words; requester i uses bits [i*WIDTH +: WIDTH]
- grant  output  NUM_REQ  one-hot, registered; grant[i] high means data_in word i is consumed at this clock edge
- busy  output  1  high in SUM or DONE
- result  output  WIDTH  final sum, held until the next result
- result_id  output  $clog2(NUM_REQ)  requester that owns result
- result_valid  output  1  one-cycle pulse; result and result_id are valid in that cycle
- result_ovf  output  1  sum overflowed WIDTH during the stream (qualified by result_valid)
- result_trunc  output  1  stream ended by MAX_LEN rather than a 0 word (qualified by result_valid)

Behaviour:
- Reset is asynchronous, active-high, on one clock. Reset values:
  - state IDLE, rr pointer 0
  - grant 0, busy 0
  - result 0, result_id 0, result_valid 0, result_ovf 0, result_trunc 0
  - internal accumulator 0, word count 0
- States: IDLE -> SUM -> DONE -> IDLE.
- IDLE:
  - If any req is high, search from the pointer upward modulo NUM_REQ; the first high req wins.
  - Latch the winner ID; clear accumulator, count and ovf flag; go to SUM.
  - The grant for the winner is high in the first SUM cycle, so req-to-grant latency is 1 cycle.
- SUM, one word per cycle while grant is high, where w = data_in of the winner:
  - w != 0: acc <= acc + w modulo 2^WIDTH; set ovf if there is a carry out; count++.
    - If count reaches MAX_LEN with this word, set trunc and go to DONE.
  - w == 0: the terminator is consumed and not added; go to DONE.
  - req of the winner low (sampled before w): abort. No result and result registers unchanged; drop grant; pointer <= winner+1; go to IDLE.
- DONE (one cycle):
  - grant 0; result <= acc; result_id <= winner; result_valid = 1; ovf and trunc presented on result_ovf and result_trunc.
  - pointer <= winner+1 modulo NUM_REQ; go to IDLE.
- Requests arriving in SUM or DONE are not lost; they are evaluated in the next IDLE cycle.
- A requester whose req is still high after its result is re-eligible at the lowest priority.
- Minimum turnaround: back-to-back streams are separated by exactly one IDLE cycle after DONE.
- An empty stream (first word 0) gives result 0 with result_valid.
- result_valid, grant and busy are all registered outputs.

Optional Feature:
- Macro: SUM_SATURATE_EN.
- Defined: addition saturates at 2^WIDTH-1; once saturated the value sticks for the rest of the stream; result_ovf = saturation occurred.
- Undefined: wrap-around modulo 2^WIDTH; result_ovf = any carry out occurred.

Test Plan (NUM_REQ=4, WIDTH=8, MAX_LEN=16 unless noted):
- req[0] only, stream 4,4,4,0 -> grant[0] high 4 cycles, then result_valid pulse with result=12, result_id=0, ovf=0, trunc=0.
- From reset, req[1] and req[3] asserted together -> 1 served first, then 3. While 3 is active, raise req[0] and req[1] -> 0 served before 1 (pointer=0 after 3).
- req[2], stream 200,100,0 -> result=44, result_ovf=1. With SUM_SATURATE_EN defined -> result=255, result_ovf=1.
- MAX_LEN=8, req[0] streaming constant 1 -> grant for exactly 8 cycles, result=8, result_trunc=1; 9th word not consumed.
- req[1] granted, streams 5 then drops req -> no result_valid, result unchanged. Pending req[2] granted 2 cycles after the drop (abort cycle, then IDLE).
- Assert reset mid-SUM -> grant, busy and result_valid go to 0 immediately without a clock. After release the pointer is 0 and a new stream 3,3,3,0 yields result=9.
